// File: rtl/soc_sram_arb_pkg.sv
// Shared types and helpers for the single-port SRAM arbiter.
// The tracking id is sized for the largest supported requester count (8).
package soc_sram_arb_pkg;

  localparam int NREQ_DEFAULT = 2;
  localparam int ID_W         = 3;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic            pending;
    logic [ID_W-1:0] id;
  } rsp_track_t;

endpackage

// File: rtl/soc_sram_rr_arbiter.sv
// Combinational round-robin pick: search starts at ptr_i and wraps modulo NREQ.
// The pointer register lives in the caller.
module soc_sram_rr_arbiter
  import soc_sram_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEFAULT,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/soc_sram_sp_arbiter.sv
// Round-robin arbiter sharing one registered-output single-port SRAM among NREQ requesters.
// Every accepted transfer gets a single response strobe one cycle later carrying mem_dout.
module soc_sram_sp_arbiter
  import soc_sram_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEFAULT,
  parameter int XLEN    = 32,
  parameter int SW      = XLEN / 8,
  parameter int WORD_AW = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_we,
  input  logic [NREQ*WORD_AW-1:0] req_addr,
  input  logic [NREQ*XLEN-1:0]    req_wdata,
  input  logic [NREQ*SW-1:0]      req_sel,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [XLEN-1:0]         rsp_rdata,
  output logic                    mem_ce,
  output logic                    mem_we,
  output logic                    mem_oe,
  output logic [WORD_AW-1:0]      mem_waddr,
  output logic [XLEN-1:0]         mem_din,
  output logic [SW-1:0]           mem_sel,
  input  logic [XLEN-1:0]         mem_dout
);

  localparam int IW = idx_width(NREQ);

  logic [IW-1:0]      ptr_q, ptr_d, gnt_idx;
  logic [NREQ-1:0]    gnt_raw, gnt;
  logic               grant;
  rsp_track_t         track_q, track_d;
  logic [WORD_AW-1:0] waddr_q, waddr_sel;
  logic [XLEN-1:0]    din_q, din_sel;
  logic               we_sel;
  logic [SW-1:0]      sel_sel;

  soc_sram_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt_raw),
    .idx_o (gnt_idx)
  );

  // Grant is combinational, so it must be masked while reset is held.
  assign gnt       = rst ? '0 : gnt_raw;
  assign grant     = |gnt;
  assign req_ready = gnt;

  always_comb begin
    waddr_sel = waddr_q;
    din_sel   = din_q;
    we_sel    = 1'b0;
    sel_sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        waddr_sel = req_addr[i*WORD_AW +: WORD_AW];
        din_sel   = req_wdata[i*XLEN +: XLEN];
        we_sel    = req_we[i];
        sel_sel   = req_sel[i*SW +: SW];
      end
    end
  end

  assign mem_ce    = grant;
  assign mem_oe    = grant;
  assign mem_we    = we_sel;
  assign mem_waddr = waddr_sel;
  assign mem_din   = din_sel;
  assign mem_sel   = sel_sel;

  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
    track_d         = track_q;
    track_d.pending = grant;
    if (grant) begin
      track_d.id = ID_W'(gnt_idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      track_q <= '0;
      waddr_q <= '0;
      din_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      track_q <= track_d;
      if (grant) begin
        waddr_q <= waddr_sel;
        din_q   <= din_sel;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = track_q.pending && (track_q.id == ID_W'(i));
    end
    rsp_rdata = track_q.pending ? mem_dout : '0;
  end

endmodule
